pq_dispatcher: RTL and testbench
================================

Name: pq_dispatcher

Overview:
- Consumer side of the AnTiQ priority queue.
- Keeps a free-running time base and watches the queue head cell (data = deadline time, id = task id).
- When the head's deadline is reached, it issues a POP to the queue and presents the popped cell to a downstream consumer over a valid/ready handshake.
- Flags late dispatches and keeps a saturating count of them.

Parameters:
- TIME_WIDTH, 16: width of time base, cell data and cell id.
- LATE_THRESH, 45: lateness (now minus deadline) above which a dispatch is marked late.
- LCNT_WIDTH, 16: width of the late-dispatch counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- enable_i  in  1  dispatch enable; when low no new pop is started.
- tick_i  in  1  advance time base by 1.
- time_load_i  in  1  load time base from time_val_i.
- time_val_i  in  TIME_WIDTH  time load value.
- head_valid_i  in  1  queue is non-empty and head_data_i/head_id_i are valid.
- head_data_i  in  TIME_WIDTH  head cell deadline.
- head_id_i  in  TIME_WIDTH  head cell id.
- pop_o  out  1  single-cycle POP request to the queue.
- out_valid_o  out  1  dispatched cell available.
- out_ready_i  in  1  consumer accepts the cell.
- out_id_o  out  TIME_WIDTH  dispatched id.
- out_time_o  out  TIME_WIDTH  dispatched deadline.
- out_late_o  out  1  dispatched cell was late.
- now_o  out  TIME_WIDTH  current time base.
- late_cnt_o  out  LCNT_WIDTH  saturating count of late dispatches.
- busy_o  out  1  FSM not in IDLE.

Behaviour:
- Reset (async, rst_ni low): all outputs and internal registers go to 0, state goes to IDLE. This takes effect immediately, including mid-pop: pop_o drops at once and any held output cell is discarded.
- Time base (now):
  - time_load_i has priority: now <= time_val_i.
  - Else if tick_i: now <= now+1, wrapping modulo 2^TIME_WIDTH (0xFFFF+1 = 0x0000).
- Due test: diff = (now - head_data_i) mod 2^TIME_WIDTH. The head is due when head_valid_i and diff[TIME_WIDTH-1]==0, i.e. the deadline lies within the past half range, wrap-safe.
- Late test: diff > LATE_THRESH (unsigned compare on diff).
- Output slot free: !out_valid_o || out_ready_i.
- FSM has 2 states:
  - IDLE: if enable_i && due && slot free, then on that edge:
    - out_id_o/out_time_o <= head; out_late_o <= late test; out_valid_o <= 1; pop_o <= 1.
    - If late, late_cnt_o increments, saturating at all-ones.
    - Next state SETTLE.
    - Otherwise stay in IDLE, pop_o <= 0.
  - SETTLE: pop_o is high for exactly this cycle and the queue removes its head at the end of it. pop_o <= 0; next state IDLE. The head inputs are not sampled in SETTLE. The new head is evaluated in the IDLE cycle that follows.
- Queue contract: the queue removes its head on the edge where pop_o is high and presents the new head (or head_valid_i=0) on the next cycle.
- Latency: a cell sampled due in cycle N shows out_valid_o=1 and pop_o=1 in cycle N+1. The earliest next pop decision is cycle N+2, so peak throughput is 1 dispatch per 2 cycles.
- Handshake:
  - out_valid_o and the output data stay stable until out_valid_o && out_ready_i.
  - On accept with no new load, out_valid_o <= 0.
  - Accept and new load in the same cycle: the new cell replaces the old one with no bubble.
- No pop is issued when head_valid_i=0 (empty queue), when the head is not due, when enable_i=0, or when the output is held with out_ready_i=0 (full).
- Deasserting enable_i during SETTLE does not abort the pop in progress.
- A time_load_i that moves now backward takes effect on the next due evaluation.
- busy_o = (state == SETTLE).

Test Plan:
- Reset, now=0, head {data=5, id=7} valid, 5 ticks → pop_o pulses one cycle after now reaches 5; out_id_o=7, out_time_o=5, out_late_o=0; no pop earlier.
- time_load 0xFFFE, head data=0x0001, tick 3 times → pop fires once now=0x0001 (wrap due); not at 0xFFFE/0xFFFF.
- now loaded 100, head data=50 → dispatch with out_late_o=1, late_cnt_o=1; head data=60 at now=100 → out_late_o=0.
- out_ready_i held 0 with three due heads → exactly one pop, out_valid_o stays 1 and out_id_o stable; raise ready → next pop in the same accept cycle with back-to-back valid, one pop per 2 cycles.
- enable_i=0 with a due head → no pop; head_valid_i=0 → no pop; re-enable → pop next cycle.
- Assert rst_ni low during SETTLE → pop_o, out_valid_o and late_cnt_o are 0 immediately; after release the FSM is in IDLE and a due head pops normally.

Source files
------------

// File: rtl/pq_dispatcher.sv
// pq_dispatcher: consumer side of the AnTiQ priority queue.
// Pops the head cell once its deadline is reached and hands it downstream over valid/ready.
module pq_dispatcher #(
  parameter int TIME_WIDTH  = 16,
  parameter int LATE_THRESH = 45,
  parameter int LCNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic                  tick_i,
  input  logic                  time_load_i,
  input  logic [TIME_WIDTH-1:0] time_val_i,
  input  logic                  head_valid_i,
  input  logic [TIME_WIDTH-1:0] head_data_i,
  input  logic [TIME_WIDTH-1:0] head_id_i,
  output logic                  pop_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [TIME_WIDTH-1:0] out_id_o,
  output logic [TIME_WIDTH-1:0] out_time_o,
  output logic                  out_late_o,
  output logic [TIME_WIDTH-1:0] now_o,
  output logic [LCNT_WIDTH-1:0] late_cnt_o,
  output logic                  busy_o
);

  typedef enum logic {IDLE = 1'b0, SETTLE = 1'b1} state_t;

  localparam logic [TIME_WIDTH-1:0] LP_THRESH = TIME_WIDTH'(LATE_THRESH);

  state_t                r_state;
  logic [TIME_WIDTH-1:0] r_now;
  logic [TIME_WIDTH-1:0] r_out_id;
  logic [TIME_WIDTH-1:0] r_out_time;
  logic                  r_out_late;
  logic                  r_out_valid;
  logic                  r_pop;
  logic [LCNT_WIDTH-1:0] r_late_cnt;

  logic [TIME_WIDTH-1:0] w_diff;
  logic                  w_due;
  logic                  w_late;
  logic                  w_slot_free;
  logic                  w_accept;
  logic                  w_fire;

  // Modular lateness: a clear MSB means the deadline lies in the past half range.
  assign w_diff      = r_now - head_data_i;
  assign w_due       = head_valid_i && !w_diff[TIME_WIDTH-1];
  assign w_late      = w_diff > LP_THRESH;
  assign w_accept    = r_out_valid && out_ready_i;
  assign w_slot_free = !r_out_valid || out_ready_i;
  assign w_fire      = enable_i && w_due && w_slot_free;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_now <= '0;
    end else if (time_load_i) begin
      r_now <= time_val_i;
    end else if (tick_i) begin
      r_now <= r_now + TIME_WIDTH'(1);
    end
  end

  // SETTLE blocks re-evaluation while the queue is still removing the popped head.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_pop       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_id    <= '0;
      r_out_time  <= '0;
      r_out_late  <= 1'b0;
      r_late_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_fire) begin
            r_out_id    <= head_id_i;
            r_out_time  <= head_data_i;
            r_out_late  <= w_late;
            r_out_valid <= 1'b1;
            r_pop       <= 1'b1;
            r_state     <= SETTLE;
            if (w_late && (r_late_cnt != '1)) begin
              r_late_cnt <= r_late_cnt + LCNT_WIDTH'(1);
            end
          end else begin
            r_pop <= 1'b0;
            if (w_accept) begin
              r_out_valid <= 1'b0;
            end
          end
        end
        SETTLE: begin
          r_pop   <= 1'b0;
          r_state <= IDLE;
          if (w_accept) begin
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_pop   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign pop_o       = r_pop;
  assign out_valid_o = r_out_valid;
  assign out_id_o    = r_out_id;
  assign out_time_o  = r_out_time;
  assign out_late_o  = r_out_late;
  assign now_o       = r_now;
  assign late_cnt_o  = r_late_cnt;
  assign busy_o      = (r_state == SETTLE);

endmodule

// File: tb/tb_pq_dispatcher.sv
// tb_pq_dispatcher: directed and random stimulus against a cycle-level reference model,
// with a scoreboard of dispatched cells popped by a separate handshake monitor.
module tb_pq_dispatcher;

  localparam int TW = 16;
  localparam int LT = 45;
  localparam int LW = 16;
  localparam int unsigned MODV = 65536;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          enable_i = 1'b0;
  logic          tick_i = 1'b0;
  logic          time_load_i = 1'b0;
  logic [TW-1:0] time_val_i = '0;
  logic          head_valid_i = 1'b0;
  logic [TW-1:0] head_data_i = '0;
  logic [TW-1:0] head_id_i = '0;
  logic          out_ready_i = 1'b0;
  logic          pop_o;
  logic          out_valid_o;
  logic [TW-1:0] out_id_o;
  logic [TW-1:0] out_time_o;
  logic          out_late_o;
  logic [TW-1:0] now_o;
  logic [LW-1:0] late_cnt_o;
  logic          busy_o;

  typedef struct packed {
    logic [TW-1:0] id;
    logic [TW-1:0] tm;
    logic          late;
  } exp_t;

  int checks = 0;
  int failures = 0;
  int popCount = 0;
  int popBase;
  bit headGate = 1'b1;
  bit seenPop;
  logic [2*TW-1:0] cellQ[$];
  exp_t sb[$];

  int unsigned mNow;
  bit mSettle;
  bit mValid;
  int unsigned mLateCnt;

  pq_dispatcher #(.TIME_WIDTH(TW), .LATE_THRESH(LT), .LCNT_WIDTH(LW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .tick_i(tick_i),
    .time_load_i(time_load_i), .time_val_i(time_val_i), .head_valid_i(head_valid_i),
    .head_data_i(head_data_i), .head_id_i(head_id_i), .pop_o(pop_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_id_o(out_id_o),
    .out_time_o(out_time_o), .out_late_o(out_late_o), .now_o(now_o),
    .late_cnt_o(late_cnt_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic driveHead();
    head_valid_i = headGate && (cellQ.size() > 0);
    if (cellQ.size() > 0) begin
      head_data_i = cellQ[0][2*TW-1:TW];
      head_id_i   = cellQ[0][TW-1:0];
    end
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
      driveHead();
    end
  endtask

  task automatic pushCell(input int unsigned data, input int unsigned id);
    cellQ.push_back({data[TW-1:0], id[TW-1:0]});
    driveHead();
  endtask

  // Queue emulator: the head leaves on the edge where POP is seen.
  always @(posedge clk_i) begin
    if (rst_ni && pop_o && cellQ.size() > 0) begin
      void'(cellQ.pop_front());
      popCount++;
    end
  end

  // Reference model: a cell is dispatched when due, enabled, the slot is free and no pop is settling.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mNow = 0;
      mSettle = 1'b0;
      mValid = 1'b0;
      mLateCnt = 0;
      sb.delete();
    end else begin
      int unsigned diff;
      bit due, late, fire;
      exp_t e;
      diff = (mNow + MODV - head_data_i) % MODV;
      due  = head_valid_i && (diff < MODV / 2);
      late = diff > LT;
      fire = !mSettle && enable_i && due && (!mValid || out_ready_i);
      if (fire) begin
        e.id = head_id_i;
        e.tm = head_data_i;
        e.late = late;
        sb.push_back(e);
        mValid = 1'b1;
        mSettle = 1'b1;
        if (late && mLateCnt < MODV - 1) mLateCnt++;
      end else begin
        mSettle = 1'b0;
        if (mValid && out_ready_i) mValid = 1'b0;
      end
      if (time_load_i) mNow = time_val_i;
      else if (tick_i) mNow = (mNow + 1) % MODV;
    end
  end

  // Handshake monitor: every accepted cell must match the oldest expected dispatch.
  always @(negedge clk_i) begin
    if (rst_ni && out_valid_o && out_ready_i) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_out", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("out_id", 32'(out_id_o), 32'(e.id));
        checkOutput("out_time", 32'(out_time_o), 32'(e.tm));
        checkOutput("out_late", 32'(out_late_o), 32'(e.late));
      end
    end
  end

  always @(negedge clk_i) begin
    if (rst_ni) begin
      checkOutput("pop", 32'(pop_o), 32'(mSettle));
      checkOutput("busy", 32'(busy_o), 32'(mSettle));
      checkOutput("out_valid", 32'(out_valid_o), 32'(mValid));
      checkOutput("now", 32'(now_o), mNow);
      checkOutput("late_cnt", 32'(late_cnt_o), mLateCnt);
    end
  end

  initial begin
    #1;
    checkOutput("rst_pop", 32'(pop_o), 32'd0);
    checkOutput("rst_valid", 32'(out_valid_o), 32'd0);
    checkOutput("rst_now", 32'(now_o), 32'd0);
    checkOutput("rst_late_cnt", 32'(late_cnt_o), 32'd0);
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    applyStimulus(3);
    rst_ni = 1'b1;

    // Basic dispatch once now reaches the deadline.
    enable_i = 1'b1;
    out_ready_i = 1'b1;
    tick_i = 1'b1;
    popBase = popCount;
    pushCell(5, 7);
    applyStimulus(5);
    checkOutput("t1_no_early_pop", 32'(popCount - popBase), 32'd0);
    applyStimulus(4);
    tick_i = 1'b0;
    checkOutput("t1_one_pop", 32'(popCount - popBase), 32'd1);

    // Wrap-safe due test across 0xFFFF -> 0x0000.
    time_load_i = 1'b1;
    time_val_i = 16'hFFFE;
    applyStimulus(1);
    time_load_i = 1'b0;
    tick_i = 1'b1;
    popBase = popCount;
    pushCell(16'h0001, 16'h0022);
    applyStimulus(3);
    checkOutput("t2_no_pop_before_wrap", 32'(popCount - popBase), 32'd0);
    applyStimulus(3);
    tick_i = 1'b0;
    checkOutput("t2_wrap_pop", 32'(popCount - popBase), 32'd1);

    // Late versus on-time dispatch at now=100.
    time_load_i = 1'b1;
    time_val_i = 16'd100;
    applyStimulus(1);
    time_load_i = 1'b0;
    pushCell(50, 16'h31);
    pushCell(60, 16'h32);
    applyStimulus(6);
    checkOutput("t3_late_cnt", 32'(late_cnt_o), 32'd1);

    // Backpressure: only one pop while the output is held.
    out_ready_i = 1'b0;
    popBase = popCount;
    pushCell(100, 16'h41);
    pushCell(100, 16'h42);
    pushCell(100, 16'h43);
    applyStimulus(6);
    checkOutput("t4_held_pops", 32'(popCount - popBase), 32'd1);
    checkOutput("t4_held_valid", 32'(out_valid_o), 32'd1);
    checkOutput("t4_held_id", 32'(out_id_o), 32'h41);
    out_ready_i = 1'b1;
    applyStimulus(8);
    checkOutput("t4_drain_pops", 32'(popCount - popBase), 32'd3);

    // Enable low and empty head both block the pop.
    enable_i = 1'b0;
    popBase = popCount;
    pushCell(100, 16'h51);
    applyStimulus(4);
    checkOutput("t5_disabled", 32'(popCount - popBase), 32'd0);
    enable_i = 1'b1;
    headGate = 1'b0;
    driveHead();
    applyStimulus(4);
    checkOutput("t5_empty", 32'(popCount - popBase), 32'd0);
    headGate = 1'b1;
    driveHead();
    applyStimulus(1);
    checkOutput("t5_reenable_pop", 32'(pop_o), 32'd1);
    applyStimulus(3);

    // Asynchronous reset in the middle of a pop.
    pushCell(10, 16'h61);
    seenPop = 1'b0;
    for (int i = 0; i < 10 && !seenPop; i++) begin
      applyStimulus(1);
      if (pop_o) seenPop = 1'b1;
    end
    checkOutput("t6_pop_seen", 32'(seenPop), 32'd1);
    rst_ni = 1'b0;
    #1;
    checkOutput("t6_rst_pop", 32'(pop_o), 32'd0);
    checkOutput("t6_rst_valid", 32'(out_valid_o), 32'd0);
    checkOutput("t6_rst_late_cnt", 32'(late_cnt_o), 32'd0);
    checkOutput("t6_rst_busy", 32'(busy_o), 32'd0);
    applyStimulus(2);
    rst_ni = 1'b1;
    popBase = popCount;
    time_load_i = 1'b1;
    time_val_i = 16'd200;
    applyStimulus(1);
    time_load_i = 1'b0;
    applyStimulus(6);
    checkOutput("t6_pop_after_reset", 32'(popCount - popBase), 32'd1);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      enable_i = ($urandom_range(0, 9) != 0);
      tick_i = $urandom_range(0, 1);
      out_ready_i = ($urandom_range(0, 9) < 7);
      time_load_i = ($urandom_range(0, 99) < 3);
      time_val_i = TW'((mNow + MODV - 60 + $urandom_range(0, 120)) % MODV);
      headGate = ($urandom_range(0, 99) < 85);
      if (cellQ.size() < 6 && $urandom_range(0, 9) < 3) begin
        cellQ.push_back({TW'((mNow + MODV - 80 + $urandom_range(0, 100)) % MODV),
                         TW'($urandom_range(0, 65535))});
      end
      driveHead();
      applyStimulus(1);
    end

    enable_i = 1'b0;
    out_ready_i = 1'b1;
    tick_i = 1'b0;
    time_load_i = 1'b0;
    applyStimulus(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
